// File: rtl/arb_rr4_drain_pkg.sv
// Shared definitions for the four-source round-robin FIFO drain arbiter:
// FSM state encoding, source count and default data width.
package arb_rr4_drain_pkg;

    localparam int N_SRC          = 4;
    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        LAT  = 2'd2,
        SEND = 2'd3
    } state_t;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arb_rr4_drain_rr_pick4.sv
// Combinational round-robin picker: first set request bit searching from
// last+1 upward and wrapping, with the previous winner given lowest priority.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        gnt_idx = last;
        found   = 1'b0;
        cand    = last;
        any     = |req;
        // Offset 4 wraps back to last itself, which is therefore searched last.
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_rr4_drain.sv
// Drains four upstream FIFOs into one downstream port, one word per four
// cycles, using a round-robin grant and a POP/LAT/SEND sequence.
module arb_rr4_drain #(
    parameter int DATA_W = arb_rr4_drain_pkg::DEFAULT_DATA_W,
    parameter int N_SRC  = arb_rr4_drain_pkg::N_SRC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              empty_in,
    input  logic [3:0]              err_in,
    input  logic [N_SRC*DATA_W-1:0] q_in,
    input  logic [3:0]              en_in,
    input  logic                    down_full,
    output logic [3:0]              pop_out,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    output logic [1:0]              src_out,
    output logic                    err_out,
    output logic                    busy
);

    import arb_rr4_drain_pkg::*;

    state_t            state_q;
    logic [3:0]        pop_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [1:0]        src_q;
    logic              err_q;
    logic              busy_q;
    logic [1:0]        last_q;
    logic [1:0]        grant_q;

    logic [3:0]        req_d;
    logic [1:0]        pick_idx;
    logic              pick_any;

    assign req_d = ~empty_in & en_in;

    rr_pick4 u_pick (
        .req     (req_d),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // The four-state walk spaces grants so a popped FIFO's empty flag has
    // settled before it is looked at again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pop_q   <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= 2'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
        end else begin
            err_q <= err_q | (|err_in);
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (!down_full && pick_any) begin
                        grant_q <= pick_idx;
                        pop_q   <= idx_to_onehot(pick_idx);
                        busy_q  <= 1'b1;
                        state_q <= POP;
                    end
                end
                POP: begin
                    pop_q   <= 4'b0000;
                    state_q <= LAT;
                end
                LAT: begin
                    data_q  <= q_in[int'(grant_q)*DATA_W +: DATA_W];
                    src_q   <= grant_q;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    valid_q <= 1'b0;
                    last_q  <= grant_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    pop_q   <= 4'b0000;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pop_out   = pop_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign src_out   = src_q;
    assign err_out   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_arb_rr4_drain.sv
// Directed self-checking bench for arb_rr4_drain: reset, single source,
// rotation, backpressure, mid-transfer reset and sticky error.
module tb_arb_rr4_drain;

    logic        clk;
    logic        reset;
    logic [3:0]  empty_in;
    logic [3:0]  err_in;
    logic [15:0] q_in;
    logic [3:0]  en_in;
    logic        down_full;
    logic [3:0]  pop_out;
    logic [3:0]  data_out;
    logic        valid_out;
    logic [1:0]  src_out;
    logic        err_out;
    logic        busy;

    int tests_run;
    int tests_failed;

    arb_rr4_drain #(.DATA_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty_in  (empty_in),
        .err_in    (err_in),
        .q_in      (q_in),
        .en_in     (en_in),
        .down_full (down_full),
        .pop_out   (pop_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .src_out   (src_out),
        .err_out   (err_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if (pop_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_pop got %b expected 0000", pop_out); end
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b expected 0", valid_out); end
        tests_run++;
        if (data_out !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h expected 0", data_out); end
        tests_run++;
        if (src_out !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_src got %0d expected 0", src_out); end
        tests_run++;
        if (err_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b expected 0", err_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    endtask

    task automatic test_single();
        empty_in  = 4'b1110;
        en_in     = 4'hF;
        q_in      = 16'h000A;
        down_full = 1'b0;
        err_in    = 4'b0000;
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if (pop_out !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_pop got %b expected 0001", pop_out); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy got %b expected 1", busy); end
        step();
        tests_run++;
        if (pop_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_pop_lat got %b expected 0000", pop_out); end
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_valid_lat got %b expected 0", valid_out); end
        step();
        tests_run++;
        if (valid_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid got %b expected 1", valid_out); end
        tests_run++;
        if (data_out !== 4'hA) begin tests_failed++; $display("[TB] FAIL single_data got %h expected a", data_out); end
        tests_run++;
        if (src_out !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_src got %0d expected 0", src_out); end
        step();
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_valid_drop got %b expected 0", valid_out); end
        tests_run++;
        if (data_out !== 4'hA) begin tests_failed++; $display("[TB] FAIL single_data_hold got %h expected a", data_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_busy_idle got %b expected 0", busy); end
        step();
        tests_run++;
        if (pop_out !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_regrant got %b expected 0001", pop_out); end
        // The FIFO goes empty after the grant; the transfer must still finish.
        empty_in = 4'hF;
        step();
        step();
        tests_run++;
        if (valid_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_no_abort got %b expected 1", valid_out); end
        step();
    endtask

    task automatic test_rotate();
        logic [1:0] exp_src;
        logic [3:0] exp_pop;
        empty_in = 4'b0000;
        en_in    = 4'hF;
        q_in     = 16'h4321;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_src = 2'(i / 4);
            exp_pop = (i % 4 == 1) ? (4'b0001 << exp_src) : 4'b0000;
            tests_run++;
            if (pop_out !== exp_pop) begin tests_failed++; $display("[TB] FAIL rotate_pop cycle %0d got %b expected %b", i, pop_out, exp_pop); end
            tests_run++;
            if (valid_out !== (i % 4 == 3)) begin tests_failed++; $display("[TB] FAIL rotate_valid cycle %0d got %b expected %b", i, valid_out, (i % 4 == 3)); end
            if (i % 4 == 3) begin
                tests_run++;
                if (src_out !== exp_src) begin tests_failed++; $display("[TB] FAIL rotate_src cycle %0d got %0d expected %0d", i, src_out, exp_src); end
                tests_run++;
                if (data_out !== 4'(exp_src) + 4'd1) begin tests_failed++; $display("[TB] FAIL rotate_data cycle %0d got %h expected %h", i, data_out, 4'(exp_src) + 4'd1); end
            end
        end
    endtask

    task automatic test_down_full();
        down_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (pop_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL full_pop cycle %0d got %b expected 0000", i, pop_out); end
            tests_run++;
            if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_busy cycle %0d got %b expected 0", i, busy); end
        end
        down_full = 1'b0;
        step();
        tests_run++;
        if (pop_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL full_release got %b expected 0010", pop_out); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_release_busy got %b expected 1", busy); end
    endtask

    task automatic test_late_full();
        step();
        down_full = 1'b1;
        step();
        tests_run++;
        if (valid_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL late_valid got %b expected 1", valid_out); end
        tests_run++;
        if (src_out !== 2'd1) begin tests_failed++; $display("[TB] FAIL late_src got %0d expected 1", src_out); end
        tests_run++;
        if (data_out !== 4'h2) begin tests_failed++; $display("[TB] FAIL late_data got %h expected 2", data_out); end
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (pop_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL late_hold_pop cycle %0d got %b expected 0000", i, pop_out); end
            tests_run++;
            if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL late_hold_busy cycle %0d got %b expected 0", i, busy); end
        end
        down_full = 1'b0;
        step();
        tests_run++;
        if (pop_out !== 4'b0100) begin tests_failed++; $display("[TB] FAIL late_next got %b expected 0100", pop_out); end
    endtask

    task automatic test_reset_lat();
        step();
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstlat_valid got %b expected 0", valid_out); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstlat_busy got %b expected 0", busy); end
        tests_run++;
        if (data_out !== 4'h0) begin tests_failed++; $display("[TB] FAIL rstlat_data got %h expected 0", data_out); end
        tests_run++;
        if (src_out !== 2'd0) begin tests_failed++; $display("[TB] FAIL rstlat_src got %0d expected 0", src_out); end
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if (pop_out !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rstlat_first got %b expected 0001", pop_out); end
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstlat_stale got %b expected 0", valid_out); end
        step();
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstlat_stale2 got %b expected 0", valid_out); end
        step();
        tests_run++;
        if (valid_out !== 1'b1 || src_out !== 2'd0 || data_out !== 4'h1) begin
            tests_failed++;
            $display("[TB] FAIL rstlat_send got v=%b s=%0d d=%h expected v=1 s=0 d=1", valid_out, src_out, data_out);
        end
    endtask

    task automatic test_error();
        en_in = 4'b0000;
        do_reset();
        err_in = 4'b0100;
        step();
        err_in = 4'b0000;
        tests_run++;
        if (err_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_set got %b expected 1", err_out); end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (err_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky cycle %0d got %b expected 1", i, err_out); end
            tests_run++;
            if (pop_out !== 4'b0000) begin tests_failed++; $display("[TB] FAIL err_pop cycle %0d got %b expected 0000", i, pop_out); end
        end
        en_in = 4'hF;
        step();
        tests_run++;
        if (pop_out !== 4'b0001) begin tests_failed++; $display("[TB] FAIL err_arb_continues got %b expected 0001", pop_out); end
        tests_run++;
        if (err_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_hold_busy got %b expected 1", err_out); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (err_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_clear got %b expected 0", err_out); end
        step();
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        empty_in     = 4'hF;
        err_in       = 4'b0000;
        q_in         = 16'h0000;
        en_in        = 4'h0;
        down_full    = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_down_full();
        test_late_full();
        test_reset_lat();
        test_error();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arb_rr4_drain.md
ARB_RR4_DRAIN -- requirements
Module: arb_rr4_drain

Interface
REQ-001: Parameter DATA_W, default 4, width of each FIFO data word.
REQ-002: Parameter N_SRC, fixed 4, number of upstream FIFOs drained.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset; one clock, async active-high reset, names clk/reset as in codebase.
REQ-005: empty_in  input  4  empty flag of FIFO i on bit i.
REQ-006: err_in  input  4  error flag of FIFO i on bit i.
REQ-007: q_in  input  4*DATA_W  read data of FIFO i on bits [i*DATA_W +: DATA_W]; valid the cycle after that FIFO's pop.
REQ-008: en_in  input  4  per-source enable mask; 0 excludes source from arbitration.
REQ-009: down_full  input  1  downstream backpressure (downstream almost_full); 1 blocks new grants.
REQ-010: pop_out  output  4  one-hot pop strobe to FIFO i.
REQ-011: data_out  output  DATA_W  forwarded word.
REQ-012: valid_out  output  1  data_out/src_out valid this cycle (downstream push).
REQ-013: src_out  output  2  index of source that produced data_out.
REQ-014: err_out  output  1  sticky OR of err_in.
REQ-015: busy  output  1  1 in any state other than IDLE.

Function
REQ-016: FSM states IDLE, POP, LAT, SEND; all outputs registered.
REQ-017: IDLE -> POP when down_full==0 and req = ~empty_in & en_in is nonzero; otherwise stay IDLE.
REQ-018: On IDLE->POP, grant = first set bit of req searching last+1, last+2, last+3, last (mod 4); grant is latched.
REQ-019: POP: pop_out[grant]=1 for exactly one cycle; POP -> LAT unconditionally.
REQ-020: LAT: pop_out=0; at end of LAT, q_in slice [grant] is captured into data_out, grant into src_out; LAT -> SEND.
REQ-021: SEND: valid_out=1 for exactly one cycle; last <= grant; SEND -> IDLE.
REQ-022: valid_out=0 and data_out/src_out hold last values outside SEND.
REQ-023: Minimum period between grants 4 cycles, so empty_in is sampled only after the FIFO's registered flags have settled after a pop; no source is ever popped when empty.
REQ-024: pop_out is never multi-hot; at most one pop every 4 cycles.
REQ-025: down_full is sampled only in IDLE; a transfer already granted completes even if down_full rises in POP/LAT/SEND.
REQ-026: Changes to en_in or empty_in after the grant do not abort the transfer.
REQ-027: err_out set when any err_in bit is 1 at a rising edge; cleared only by reset; arbitration continues while err_out=1.
REQ-028: Single requester: repeatedly granted, one word per 4 cycles; all four requesting: grants rotate 0,1,2,3,0,...

Reset
REQ-029: reset=1 forces immediately (asynchronously): state=IDLE, pop_out=0, valid_out=0, data_out=0, src_out=0, err_out=0, busy=0, last=3 (so first search starts at source 0).
REQ-030: Reset asserted mid-transfer discards the transfer; no valid_out for it after release.
REQ-031: First grant possible on the first rising edge after reset deasserts.

Structure
REQ-032: Shared package holds the FSM state encoding (2-bit: IDLE=0, POP=1, LAT=2, SEND=3), N_SRC, and the default DATA_W.
REQ-033: Round-robin priority picker is one combinational sub-module rr_pick4 (inputs req[3:0], last[1:0]; outputs gnt_idx[1:0], any).

Verification
REQ-034: Reset, then empty_in=4'b1110, en_in=4'hF, q_in[3:0]=4'hA, down_full=0 -> pop_out=4'b0001 at cycle 2, valid_out=1 with data_out=4'hA, src_out=0 at cycle 4.
REQ-035: All sources non-empty, q_in slices 1,2,3,4 held -> src_out sequence 0,1,2,3,0, data_out 1,2,3,4,1, valid_out spaced exactly 4 cycles apart.
REQ-036: down_full=1 with req nonzero for 10 cycles -> pop_out=0, busy=0 throughout; down_full=0 -> grant on next edge.
REQ-037: down_full rises during LAT -> SEND still occurs with valid_out=1; next grant withheld until down_full=0.
REQ-038: reset pulsed during LAT -> valid_out stays 0, outputs at reset values immediately, next grant starts from source 0.
REQ-039: err_in=4'b0100 for one cycle, en_in=4'b0000 -> err_out=1 and stays 1 until reset; pop_out stays 0.
